// File: rtl/multicycle_control_pkg.sv
// Shared types for the multi-cycle RV32I controller:
// FSM states, opcode values and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_LOAD,
        CLS_STORE,
        CLS_RTYPE,
        CLS_IALU,
        CLS_BRANCH
    } op_class_t;

    function automatic op_class_t op_class(input logic [6:0] op);
        case (op)
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_RTYPE:  return CLS_RTYPE;
            OP_IALU:   return CLS_IALU;
            OP_BRANCH: return CLS_BRANCH;
            default:   return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: IR fields and status in,
// strobes and mux selects out.
interface multicycle_control_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       illegal_instr;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write,
        output adr_src, alu_src_a, alu_src_b, alu_ctrl,
        output result_src, imm_src, illegal_instr
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write,
        input  adr_src, alu_src_a, alu_src_b, alu_ctrl,
        input  result_src, imm_src, illegal_instr
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Maps opcode class + funct fields to an ALU op and a legality flag
// used by DECODE to divert unsupported encodings.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  op_class_t  i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [2:0] o_alu_ctrl,
    output logic       o_legal
);

    logic w_rtype;
    logic w_alt;

    assign w_rtype = (i_class == CLS_RTYPE);
    // funct7_5 only means something for R-type; it picks sub on 000
    assign w_alt   = w_rtype & i_funct7_5;

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_legal    = 1'b0;
        case (i_class)
            CLS_LOAD, CLS_STORE: begin
                o_legal = (i_funct3 == 3'b010);
            end
            CLS_BRANCH: begin
                o_alu_ctrl = ALU_SUB;
                o_legal    = (i_funct3 == 3'b000) | (i_funct3 == 3'b001);
            end
            CLS_RTYPE, CLS_IALU: begin
                case (i_funct3)
                    3'b000: begin
                        o_alu_ctrl = w_alt ? ALU_SUB : ALU_ADD;
                        o_legal    = 1'b1;
                    end
                    3'b111: begin
                        o_alu_ctrl = ALU_AND;
                        o_legal    = ~w_alt;
                    end
                    3'b110: begin
                        o_alu_ctrl = ALU_OR;
                        o_legal    = ~w_alt;
                    end
                    3'b010: begin
                        o_alu_ctrl = ALU_SLT;
                        o_legal    = ~w_alt;
                    end
                    default: o_legal = 1'b0;
                endcase
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore controller for the multi-cycle RV32I core: walks each
// instruction through fetch/decode/execute/memory/writeback.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    op_class_t  w_class;
    logic [2:0] w_alu_ctrl;
    logic       w_legal;
    logic       w_taken;

    assign w_class = op_class(bus.opcode);

    alu_decoder u_alu_dec (
        .i_class    (w_class),
        .i_funct3   (bus.funct3),
        .i_funct7_5 (bus.funct7_5),
        .o_alu_ctrl (w_alu_ctrl),
        .o_legal    (w_legal)
    );

    assign w_taken = ((bus.funct3 == 3'b000) &  bus.zero) |
                     ((bus.funct3 == 3'b001) & ~bus.zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ILLEGAL) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next            = r_state;
        bus.pc_write      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.adr_src       = 1'b0;
        bus.alu_src_a     = SRCA_PC;
        bus.alu_src_b     = SRCB_RS2;
        bus.alu_ctrl      = ALU_ADD;
        bus.result_src    = RES_ALUOUT;
        bus.imm_src       = IMM_I;
        bus.illegal_instr = r_illegal;
        case (r_state)
            S_FETCH: begin
                bus.mem_read   = 1'b1;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    w_next       = S_DECODE;
                end
            end
            S_DECODE: begin
                // branch target is precomputed into ALUOut here
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                bus.imm_src   = IMM_B;
                if (!w_legal) begin
                    w_next = S_ILLEGAL;
                end else begin
                    case (w_class)
                        CLS_LOAD,
                        CLS_STORE:  w_next = S_MEMADR;
                        CLS_RTYPE:  w_next = S_EXECR;
                        CLS_IALU:   w_next = S_EXECI;
                        CLS_BRANCH: w_next = S_BRANCH;
                        default:    w_next = S_ILLEGAL;
                    endcase
                end
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                if (w_class == CLS_STORE) begin
                    bus.imm_src = IMM_S;
                    w_next      = S_MEMWRITE;
                end else begin
                    w_next = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                bus.mem_read = 1'b1;
                bus.adr_src  = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                bus.reg_write  = 1'b1;
                w_next         = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.mem_write = 1'b1;
                bus.adr_src   = 1'b1;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_RS2;
                bus.alu_ctrl  = w_alu_ctrl;
                w_next        = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_ctrl  = w_alu_ctrl;
                w_next        = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_RS2;
                bus.alu_ctrl  = ALU_SUB;
                bus.pc_write  = w_taken;
                w_next        = S_FETCH;
            end
            S_ILLEGAL: begin
                bus.illegal_instr = 1'b1;
                w_next            = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        // reset silences every strobe in the same cycle it is applied
        if (rst) begin
            w_next            = S_FETCH;
            bus.pc_write      = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.adr_src       = 1'b0;
            bus.alu_src_a     = 2'b00;
            bus.alu_src_b     = 2'b00;
            bus.alu_ctrl      = 3'b000;
            bus.result_src    = 2'b00;
            bus.imm_src       = 2'b00;
            bus.illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction scenarios plus
// randomized streams checked against a per-instruction behaviour model.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] res;
        logic [1:0] imm;
        logic       ill;
    } obs_t;

    typedef struct {
        bit         legal;
        int         lat;
        int         regw;
        int         memw;
        int         pcw;
        int         rd;
        logic [2:0] alu;
        bit         alu_op;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    obs_t tr [64];
    int   n_cyc, c_regw, c_memw, c_pcw, c_irw, c_rd;
    logic [1:0] rs_wb;
    bit   sticky;

    function automatic obs_t sample();
        obs_t o;
        o = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
             bus.mem_write, bus.adr_src, bus.alu_src_a, bus.alu_src_b,
             bus.alu_ctrl, bus.result_src, bus.imm_src, bus.illegal_instr};
        return o;
    endfunction

    // Instruction behaviour from the ISA subset: legality, cycle count
    // and how many times each strobe should fire.
    function automatic exp_t model(input logic [31:0] w, input int fw,
                                   input int mw, input logic zv);
        exp_t e;
        logic [2:0] f3;
        logic f7;
        int cls;
        f3 = w[14:12];
        f7 = w[30];
        e = '{legal: 0, lat: 0, regw: 0, memw: 0, pcw: 1, rd: 0,
              alu: 3'b000, alu_op: 0};
        case (w[6:0])
            7'h03:   cls = 1;
            7'h23:   cls = 2;
            7'h33:   cls = 3;
            7'h13:   cls = 4;
            7'h63:   cls = 5;
            default: cls = 0;
        endcase
        case (cls)
            1, 2: e.legal = (f3 == 3'd2);
            3:    e.legal = (f3 inside {3'd0, 3'd7, 3'd6, 3'd2}) &&
                            (!f7 || f3 == 3'd0);
            4:    e.legal = (f3 inside {3'd0, 3'd7, 3'd6, 3'd2});
            5:    e.legal = (f3 < 3'd2);
            default: e.legal = 0;
        endcase
        if (f3 == 3'd0)      e.alu = (cls == 3 && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'd7) e.alu = 3'b010;
        else if (f3 == 3'd6) e.alu = 3'b011;
        else                 e.alu = 3'b101;
        if (!e.legal) begin
            e.lat = fw + 3;
        end else begin
            case (cls)
                1: begin e.lat = fw + mw + 5; e.regw = 1; e.rd = mw + 1; end
                2: begin e.lat = fw + mw + 4; e.memw = mw + 1; end
                3, 4: begin e.lat = fw + 4; e.regw = 1; e.alu_op = 1; end
                default: begin
                    e.lat = fw + 3;
                    e.pcw = 1 + ((f3 == 3'd0) ? int'(zv) : int'(!zv));
                end
            endcase
        end
        return e;
    endfunction

    task automatic apply_ir(input logic [31:0] w);
        bus.opcode   = w[6:0];
        bus.funct3   = w[14:12];
        bus.funct7_5 = w[30];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_ready = 1'b0;
        sticky = 0;
        #1;
    endtask

    // Acts as the memory: answers requests after fw (fetch) or mw (data)
    // wait cycles, and loads the IR fields once ir_write is seen.
    // Entered and left at posedge+2 of a FETCH cycle.
    task automatic run_instr(input logic [31:0] ins, input int fw,
                             input int mw, input logic zv);
        int  waited;
        bit  seen;
        bit  done;
        n_cyc = 0; c_regw = 0; c_memw = 0; c_pcw = 0; c_irw = 0; c_rd = 0;
        rs_wb = 2'b11;
        waited = 0; seen = 0; done = 0;
        bus.zero = zv;
        while (!done && n_cyc < 40) begin
            if (bus.mem_read || bus.mem_write) begin
                if (seen && bus.mem_read && !bus.adr_src) begin
                    done = 1;
                    bus.mem_ready = 1'b0;
                end else begin
                    bus.mem_ready = (waited >= (seen ? mw : fw));
                    waited = bus.mem_ready ? 0 : waited + 1;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            if (!done) begin
                @(negedge clk);
                tr[n_cyc] = sample();
                c_regw += int'(tr[n_cyc].reg_write);
                c_memw += int'(tr[n_cyc].mem_write);
                c_pcw  += int'(tr[n_cyc].pc_write);
                c_irw  += int'(tr[n_cyc].ir_write);
                c_rd   += int'(tr[n_cyc].mem_read & tr[n_cyc].adr_src);
                if (tr[n_cyc].reg_write) rs_wb = tr[n_cyc].res;
                if (tr[n_cyc].ir_write) seen = 1;
                n_cyc++;
                @(posedge clk);
                #1 if (tr[n_cyc-1].ir_write) apply_ir(ins);
                #1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout ins=%08h cycles=%0d want next fetch", ins, n_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        apply_ir(32'h002081B3);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sample() !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", sample());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (!bus.mem_read || bus.adr_src || bus.alu_src_b !== 2'b10 ||
            bus.result_src !== 2'b10 || bus.ir_write) begin
            errors++; $display("FAIL first_fetch got %h want fetch pattern", sample());
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_add();
        run_instr(32'h002081B3, 0, 0, 1'b0);
        checks++;
        if (n_cyc !== 4) begin
            errors++; $display("FAIL add_cycles got %0d want 4", n_cyc);
        end
        checks++;
        if (!tr[0].ir_write || !tr[0].pc_write || !tr[0].mem_read) begin
            errors++; $display("FAIL add_fetch got %h want ir/pc write", tr[0]);
        end
        checks++;
        if (tr[2].alu !== 3'b000 || tr[2].src_a !== 2'b10 || tr[2].src_b !== 2'b00) begin
            errors++; $display("FAIL add_exec got %h want alu 0 a 2 b 0", tr[2]);
        end
        checks++;
        if (c_regw !== 1 || !tr[3].reg_write || tr[3].res !== 2'b00) begin
            errors++; $display("FAIL add_wb got regw=%0d want 1 in cycle 4", c_regw);
        end
    endtask

    task automatic test_lw();
        run_instr(32'h0080A283, 0, 2, 1'b0);
        checks++;
        if (n_cyc !== 7) begin
            errors++; $display("FAIL lw_cycles got %0d want 7", n_cyc);
        end
        checks++;
        if (tr[2].imm !== 2'b00 || tr[2].src_a !== 2'b10) begin
            errors++; $display("FAIL lw_memadr got %h want imm 0", tr[2]);
        end
        checks++;
        if (c_rd !== 3) begin
            errors++; $display("FAIL lw_read_hold got %0d want 3", c_rd);
        end
        checks++;
        if (c_regw !== 1 || rs_wb !== 2'b01) begin
            errors++; $display("FAIL lw_wb got regw=%0d res=%0d want 1/1", c_regw, rs_wb);
        end
    endtask

    task automatic test_sw();
        run_instr(32'h0020A223, 0, 0, 1'b0);
        checks++;
        if (tr[2].imm !== 2'b01) begin
            errors++; $display("FAIL sw_imm got %0d want 1", tr[2].imm);
        end
        checks++;
        if (c_memw !== 1 || c_regw !== 0 || n_cyc !== 4) begin
            errors++;
            $display("FAIL sw_strobes got memw=%0d regw=%0d cyc=%0d want 1/0/4",
                     c_memw, c_regw, n_cyc);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [3];
        logic        zv  [3];
        logic        exp [3];
        ins = '{32'h00208463, 32'h00208463, 32'h00209463};
        zv  = '{1'b1, 1'b0, 1'b0};
        exp = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_instr(ins[i], 0, 0, zv[i]);
            checks++;
            if (n_cyc !== 3 || tr[2].pc_write !== exp[i] || tr[2].alu !== 3'b001) begin
                errors++;
                $display("FAIL branch%0d got pcw=%b cyc=%0d want %b/3",
                         i, tr[2].pc_write, n_cyc, exp[i]);
            end
            checks++;
            if (tr[1].imm !== 2'b10) begin
                errors++; $display("FAIL branch%0d_dec_imm got %0d want 2", i, tr[1].imm);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        checks++;
        if (bus.illegal_instr !== 1'b0) begin
            errors++; $display("FAIL ill_clear got %b want 0", bus.illegal_instr);
        end
        run_instr(32'h0000007F, 0, 0, 1'b0);
        checks++;
        if (n_cyc !== 3 || c_regw !== 0 || c_memw !== 0 || !tr[2].ill) begin
            errors++; $display("FAIL ill_op got cyc=%0d ill=%b want 3/1", n_cyc, tr[2].ill);
        end
        run_instr(32'h002091B3, 0, 0, 1'b0);
        checks++;
        if (n_cyc !== 3 || c_regw !== 0 || bus.illegal_instr !== 1'b1) begin
            errors++; $display("FAIL ill_f3 got cyc=%0d ill=%b want 3/1", n_cyc, bus.illegal_instr);
        end
        run_instr(32'h002081B3, 0, 0, 1'b0);
        checks++;
        if (bus.illegal_instr !== 1'b1 || n_cyc !== 4) begin
            errors++; $display("FAIL ill_sticky got %b want 1", bus.illegal_instr);
        end
        do_reset();
        checks++;
        if (bus.illegal_instr !== 1'b0) begin
            errors++; $display("FAIL ill_rst got %b want 0", bus.illegal_instr);
        end
    endtask

    task automatic test_rst_mid();
        int memw = 0;
        do_reset();
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1 apply_ir(32'h0020A223);
        #1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (!bus.mem_write) begin
            errors++; $display("FAIL rstmid_pre got mem_write=%b want 1", bus.mem_write);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sample() !== '0) begin
            errors++; $display("FAIL rstmid_zero got %h want 0", sample());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            memw += int'(bus.mem_write | bus.reg_write);
        end
        checks++;
        if (memw !== 0 || !bus.mem_read || bus.adr_src) begin
            errors++; $display("FAIL rstmid_after got strobes=%0d want 0 and fetch", memw);
        end
        @(posedge clk);
        #2;
        run_instr(32'h002081B3, 0, 0, 1'b0);
        checks++;
        if (n_cyc !== 4 || c_regw !== 1) begin
            errors++; $display("FAIL rstmid_resume got cyc=%0d want 4", n_cyc);
        end
    endtask

    task automatic test_random();
        logic [2:0]  lst [4];
        logic [31:0] w;
        int          fw, mw;
        logic        zv;
        exp_t        e;
        lst = '{3'd0, 3'd7, 3'd6, 3'd2};
        do_reset();
        for (int n = 0; n < 80; n++) begin
            w  = $urandom;
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            zv = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
                1: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
                2, 3: begin
                    w[6:0] = 7'h33;
                    w[14:12] = lst[$urandom_range(0, 3)];
                    if (w[14:12] != 3'd0) w[30] = 1'b0;
                end
                4, 5: begin w[6:0] = 7'h13; w[14:12] = lst[$urandom_range(0, 3)]; end
                6, 7: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 1)); end
                8: ;
                default: begin
                    case ($urandom_range(0, 4))
                        0: w[6:0] = 7'h03;
                        1: w[6:0] = 7'h23;
                        2: w[6:0] = 7'h33;
                        3: w[6:0] = 7'h13;
                        default: w[6:0] = 7'h63;
                    endcase
                end
            endcase
            e = model(w, fw, mw, zv);
            if (!e.legal) sticky = 1;
            run_instr(w, fw, mw, zv);
            checks++;
            if (n_cyc !== e.lat || c_regw !== e.regw || c_memw !== e.memw ||
                c_pcw !== e.pcw || c_irw !== 1 || c_rd !== e.rd) begin
                errors++;
                $display("FAIL rand%0d ins=%08h got cyc=%0d rw=%0d mw=%0d pw=%0d rd=%0d want %0d/%0d/%0d/%0d/%0d",
                         n, w, n_cyc, c_regw, c_memw, c_pcw, c_rd,
                         e.lat, e.regw, e.memw, e.pcw, e.rd);
            end
            checks++;
            if (bus.illegal_instr !== sticky) begin
                errors++;
                $display("FAIL rand%0d_ill got %b want %b", n, bus.illegal_instr, sticky);
            end
            if (e.alu_op) begin
                checks++;
                if (tr[fw+2].alu !== e.alu) begin
                    errors++;
                    $display("FAIL rand%0d_alu got %0d want %0d", n, tr[fw+2].alu, e.alu);
                end
            end
        end
    endtask

    initial begin
        bus.opcode = '0;
        bus.funct3 = '0;
        bus.funct7_5 = 1'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        sticky = 0;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_branch();
        test_illegal();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main controller for the multi-cycle RV32I core. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select, including `imm_src` for the immediate sign-extender, and stalls on a shared instruction/data memory `mem_ready` handshake. It sits between the instruction register fields and the datapath registers (PC, IR, ALUOut, data register, register file).

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7_5` in 1: IR[30].
- `zero` in 1: ALU zero flag (combinational, current cycle).
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pc_write` out 1: load PC from result mux.
- `ir_write` out 1: load IR (and old-PC register) from memory read data.
- `reg_write` out 1: register file write enable.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `adr_src` out 1: memory address select; 0=PC, 1=ALUOut.
- `alu_src_a` out 2: ALU A select; 00=PC, 01=old PC, 10=rs1.
- `alu_src_b` out 2: ALU B select; 00=rs2, 01=imm, 10=const 4.
- `alu_ctrl` out 3: ALU op; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `result_src` out 2: result mux select; 00=ALUOut, 01=data reg, 10=ALU result.
- `imm_src` out 2: sign-extender format; 00=I, 01=S, 10=B (11 also decodes as I; never driven).
- `illegal_instr` out 1: sticky flag, set on an unsupported encoding.

## Operation
- Supported instructions: lw (0000011), sw (0100011), R-type (0110011: add, sub, and, or, slt), I-ALU (0010011: addi, andi, ori, slti), beq/bne (1100011). Anything else is illegal.
- States and Moore outputs. Outputs not listed are 0; `alu_ctrl` defaults to add and `imm_src` defaults to 00.
  - FETCH: `mem_read`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10. While `mem_ready`: `ir_write`=1 and `pc_write`=1, then go to DECODE. Otherwise hold in FETCH.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, `imm_src`=10 (branch target into ALUOut).
    - lw/sw go to MEMADR.
    - R-type goes to EXECR; I-ALU goes to EXECI; branch goes to BRANCH.
    - Any other opcode, or an illegal funct3/funct7 combination, goes to ILLEGAL.
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, `imm_src`=00 for lw and 01 for sw. lw goes to MEMREAD; sw goes to MEMWRITE.
  - MEMREAD: `mem_read`=1, `adr_src`=1. Hold until `mem_ready`, then go to MEMWB.
  - MEMWB: `result_src`=01, `reg_write`=1. Next is FETCH.
  - MEMWRITE: `mem_write`=1, `adr_src`=1. Hold until `mem_ready`, then go to FETCH.
  - EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_ctrl` from the decoder (funct7_5=1 with funct3=000 selects sub). Next is ALUWB.
  - EXECI: `alu_src_a`=10, `alu_src_b`=01, `imm_src`=00, `alu_ctrl` from the decoder (funct7_5 ignored). Next is ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1. Next is FETCH.
  - BRANCH: `alu_src_a`=10, `alu_src_b`=00, `alu_ctrl`=sub, `result_src`=00.
    - `pc_write` = (funct3==000 & `zero`) | (funct3==001 & !`zero`). Other funct3 values were already rejected in DECODE.
    - Next is FETCH.
  - ILLEGAL: no strobes; sets `illegal_instr`. Next is FETCH. PC was already advanced by 4, so execution continues.
- `illegal_instr` is cleared only by `rst`.

## Timing
- Reset: while `rst`=1, the state register loads FETCH and every output is forced to 0, including `illegal_instr`. Selects read 0. The first fetch request appears in the cycle after `rst` deasserts.
- `rst` mid-instruction abandons the instruction. No `reg_write` or `mem_write` may occur in or after the `rst` cycle until a new FETCH completes.
- Memory handshake:
  - `mem_read`/`mem_write` and `adr_src` are held stable until the cycle in which `mem_ready`=1.
  - A transfer completes in exactly that cycle; `ir_write`/`pc_write` in FETCH pulse only then.
  - `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.
- Latency with zero wait states (`mem_ready` tied 1): branch 3 cycles, R/I-ALU 4, sw 4, lw 5. Each wait cycle in a memory state adds exactly 1.
- All outputs are decoded from state plus the IR fields, `zero` and `mem_ready`. No output registers.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode localparams;
  - `alu_ctrl`, `imm_src`, `alu_src_a`, `alu_src_b` and `result_src` encodings.
- Sub-module `alu_decoder`: combinational mapping from (opcode class, funct3, funct7_5) to `alu_ctrl` plus a `legal` flag. DECODE uses the flag for the ILLEGAL check.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB. `alu_ctrl`=000 in EXECR; `reg_write`=1 only in cycle 4; back to FETCH in cycle 5.
- `lw x5,8(x1)` (0x0080A283) with `mem_ready` low for 2 cycles in MEMREAD → `imm_src`=00 in MEMADR; `mem_read`/`adr_src`=1 held 3 cycles; `reg_write` with `result_src`=01 once; 7 cycles total.
- `sw x2,4(x1)` (0x0020A223) → `imm_src`=01 in MEMADR; `mem_write`=1 for 1 cycle; `reg_write` never asserted.
- `beq` (0x00208463) with `zero`=1, then the same with `zero`=0; then `bne` (0x00209463) with `zero`=0 → `pc_write` in BRANCH is 1, 0, 1. `imm_src`=10 in DECODE every time.
- Opcode 0x7F, and R-type funct3=001 → ILLEGAL visited and `illegal_instr`=1 until `rst`. No `reg_write`/`mem_write`; next FETCH follows.
- `rst` asserted during MEMWRITE with `mem_ready`=0 → outputs 0 that cycle, FETCH next, no `mem_write` pulse escapes.
